// File: rtl/img_proc_pkg.sv
// Shared image-processing constants: default pixel/line geometry and counter widths.
package img_proc_pkg;
   localparam int PIX_W_DEF     = 24;
   localparam int PIC_WIDTH_DEF = 480;
   localparam int COL_W         = 9;
   localparam int LINE_W        = 2;

   typedef logic [COL_W-1:0]  col_t;
   typedef logic [LINE_W-1:0] line_t;

   localparam line_t LINES_PRIMED = 2'd2;
endpackage

// File: rtl/line_ram.sv
// Single-clock line store: registered read and write ports, old data returned when both hit one address.
module line_ram
   import img_proc_pkg::*;
#(
   parameter int WIDTH = PIX_W_DEF,
   parameter int DEPTH = PIC_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             re_i,
   input  col_t             raddr_i,
   output logic [WIDTH-1:0] rdata_o,
   input  logic             we_i,
   input  col_t             waddr_i,
   input  logic [WIDTH-1:0] wdata_i
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i[AW-1:0]] <= wdata_i;
   end

   // Only the read register is reset, so outputs fed from it come up as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i[AW-1:0]];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/line_buffer_3row.sv
// Three-row vertical window over a raster stream using two line stores.
// LINE_BUFFER_PRIME_GATE_EN: suppress valid_out until two full lines are stored.
module line_buffer_3row
   import img_proc_pkg::*;
#(
   parameter int WIDTH     = PIX_W_DEF,
   parameter int PIC_WIDTH = PIC_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sof,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] din,
   output logic             valid_out,
   output logic [WIDTH-1:0] dout1,
   output logic [WIDTH-1:0] dout2,
   output logic [WIDTH-1:0] dout3
);
   localparam col_t LAST_COL = col_t'(PIC_WIDTH - 1);

   col_t             col_q, col_d, col_cur, pend_col_q;
   line_t            lines_q, lines_d, lines_cur;
   logic             pend_q, vld_q;
   logic [WIDTH-1:0] d3_q, a_rdata, b_rdata;

   always_comb begin
      col_cur   = sof ? '0 : col_q;
      lines_cur = sof ? '0 : lines_q;
      col_d     = col_cur;
      lines_d   = lines_cur;
      if (valid_in) begin
         if (col_cur == LAST_COL) begin
            col_d = '0;
            if (lines_cur != LINES_PRIMED) lines_d = lines_cur + 1'b1;
         end else begin
            col_d = col_cur + 1'b1;
         end
      end
   end

   line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH)) u_store_a (
      .clk(clk), .rst_n(rst_n),
      .re_i(valid_in), .raddr_i(col_cur), .rdata_o(a_rdata),
      .we_i(valid_in), .waddr_i(col_cur), .wdata_i(din)
   );

   // Store B takes A's old word one cycle later, once it sits in A's read register.
   // The column is not revisited for at least PIC_WIDTH pixels except right after
   // sof, where the top row is masked anyway.
   line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH)) u_store_b (
      .clk(clk), .rst_n(rst_n),
      .re_i(valid_in), .raddr_i(col_cur), .rdata_o(b_rdata),
      .we_i(pend_q), .waddr_i(pend_col_q), .wdata_i(a_rdata)
   );

`ifdef LINE_BUFFER_PRIME_GATE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= 1'b0;
      else        vld_q <= valid_in && (lines_cur == LINES_PRIMED);
   end

   assign dout1 = b_rdata;
   assign dout2 = a_rdata;
`else
   logic zero1_q, zero2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         zero1_q <= 1'b1;
         zero2_q <= 1'b1;
      end else begin
         vld_q <= valid_in;
         if (valid_in) begin
            zero1_q <= (lines_cur != LINES_PRIMED);
            zero2_q <= (lines_cur == '0);
         end
      end
   end

   assign dout1 = zero1_q ? '0 : b_rdata;
   assign dout2 = zero2_q ? '0 : a_rdata;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         lines_q    <= '0;
         pend_q     <= 1'b0;
         pend_col_q <= '0;
         d3_q       <= '0;
      end else begin
         col_q      <= col_d;
         lines_q    <= lines_d;
         pend_q     <= valid_in;
         pend_col_q <= col_cur;
         if (valid_in) d3_q <= din;
      end
   end

   assign valid_out = vld_q;
   assign dout3     = d3_q;
endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row; expectations follow the build selected by LINE_BUFFER_PRIME_GATE_EN.
module tb_line_buffer_3row;
   localparam int W = 24;

`ifdef LINE_BUFFER_PRIME_GATE_EN
   localparam bit GATED = 1'b1;
`else
   localparam bit GATED = 1'b0;
`endif

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         sof = 1'b0, vin = 1'b0;
   logic [W-1:0] din = '0;
   logic         vout;
   logic [W-1:0] d1, d2, d3;

   logic         bsof = 1'b0, bvin = 1'b0;
   logic [W-1:0] bdin = '0;
   logic         bvout;
   logic [W-1:0] bd1, bd2, bd3;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .sof(sof), .valid_in(vin), .din(din),
      .valid_out(vout), .dout1(d1), .dout2(d2), .dout3(d3)
   );

   line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(511)) dut_wide (
      .clk(clk), .rst_n(rst_n), .sof(bsof), .valid_in(bvin), .din(bdin),
      .valid_out(bvout), .dout1(bd1), .dout2(bd2), .dout3(bd3)
   );

   typedef struct {
      int           pix;
      logic         vld;
      logic [W-1:0] e1, e2, e3;
   } vec_t;

   vec_t         tab [6];
   logic         ov [24];
   logic [W-1:0] o1 [24], o2 [24], o3 [24];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push(input logic s, input logic [W-1:0] v);
      sof = s; vin = 1'b1; din = v;
      @(posedge clk); #1;
      sof = 1'b0; vin = 1'b0;
   endtask

   task automatic bubble();
      vin = 1'b0;
      @(posedge clk); #1;
   endtask

   // Pixel p of an 8-wide frame carrying value p: window is p-16 / p-8 / p.
   task automatic check_pix(input string tag, input int p);
      logic         ev;
      logic [W-1:0] e1, e2;
      ev = GATED ? (p >= 16) : 1'b1;
      e1 = (p >= 16) ? W'(p - 16) : '0;
      e2 = (p >= 8)  ? W'(p - 8)  : '0;
      chk($sformatf("%s_vld_p%0d", tag, p), {23'd0, vout}, {23'd0, ev});
      if (ev) begin
         chk($sformatf("%s_d1_p%0d", tag, p), d1, e1);
         chk($sformatf("%s_d2_p%0d", tag, p), d2, e2);
         chk($sformatf("%s_d3_p%0d", tag, p), d3, W'(p));
      end
   endtask

   initial begin
      if (GATED) begin
         tab[0] = '{0,  1'b0, 0, 0, 0};
         tab[1] = '{8,  1'b0, 0, 0, 0};
         tab[2] = '{15, 1'b0, 0, 0, 0};
         tab[3] = '{16, 1'b1, 0, 8, 16};
         tab[4] = '{19, 1'b1, 3, 11, 19};
         tab[5] = '{23, 1'b1, 7, 15, 23};
      end else begin
         tab[0] = '{0,  1'b1, 0, 0, 0};
         tab[1] = '{3,  1'b1, 0, 0, 3};
         tab[2] = '{8,  1'b1, 0, 0, 8};
         tab[3] = '{11, 1'b1, 0, 3, 11};
         tab[4] = '{19, 1'b1, 3, 11, 19};
         tab[5] = '{23, 1'b1, 7, 15, 23};
      end

      // Reset state
      #2;
      chk("rst_vld", {23'd0, vout}, '0);
      chk("rst_d1", d1, '0);
      chk("rst_d2", d2, '0);
      chk("rst_d3", d3, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Contiguous frame, checked against the table
      for (int p = 0; p < 24; p++) begin
         push(p == 0, W'(p));
         ov[p] = vout; o1[p] = d1; o2[p] = d2; o3[p] = d3;
      end
      for (int i = 0; i < 6; i++) begin
         int p;
         p = tab[i].pix;
         chk($sformatf("tab_vld_p%0d", p), {23'd0, ov[p]}, {23'd0, tab[i].vld});
         if (tab[i].vld) begin
            chk($sformatf("tab_d1_p%0d", p), o1[p], tab[i].e1);
            chk($sformatf("tab_d2_p%0d", p), o2[p], tab[i].e2);
            chk($sformatf("tab_d3_p%0d", p), o3[p], tab[i].e3);
         end
      end

      // Bubble after every pixel: same window, valid low and data held in bubbles
      for (int p = 0; p < 24; p++) begin
         push(p == 0, W'(p));
         check_pix("bub", p);
         bubble();
         chk($sformatf("bub_gap_vld_p%0d", p), {23'd0, vout}, '0);
         if (!GATED || p >= 16) begin
            chk($sformatf("bub_hold_d1_p%0d", p), d1, (p >= 16) ? W'(p - 16) : '0);
            chk($sformatf("bub_hold_d2_p%0d", p), d2, (p >= 8) ? W'(p - 8) : '0);
            chk($sformatf("bub_hold_d3_p%0d", p), d3, W'(p));
         end
      end

      // Asynchronous reset while pixel 13 is being presented
      for (int p = 0; p < 13; p++) push(p == 0, W'(p));
      vin = 1'b1; din = W'(13);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", {23'd0, vout}, '0);
      chk("mid_rst_d1", d1, '0);
      chk("mid_rst_d2", d2, '0);
      chk("mid_rst_d3", d3, '0);
      vin = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int p = 0; p < 24; p++) begin
         push(1'b0, W'(p));
         check_pix("post_rst", p);
      end

      // sof arrives with a pixel at column 5 of the next line
      for (int c = 0; c < 5; c++) push(1'b0, W'(100 + c));
      for (int p = 0; p < 24; p++) begin
         push(p == 0, W'(p));
         check_pix("sof_mid", p);
      end

      // 511-wide instance: column wrap at 510 and last-column window
      for (int l = 0; l < 3; l++) begin
         for (int c = 0; c < 511; c++) begin
            bsof = (l == 0 && c == 0); bvin = 1'b1; bdin = W'(c);
            @(posedge clk); #1;
            bsof = 1'b0; bvin = 1'b0;
            if (l == 2 && (c == 1 || c == 510)) begin
               chk($sformatf("wide_vld_c%0d", c), {23'd0, bvout}, 24'd1);
               chk($sformatf("wide_d1_c%0d", c), bd1, W'(c));
               chk($sformatf("wide_d2_c%0d", c), bd2, W'(c));
               chk($sformatf("wide_d3_c%0d", c), bd3, W'(c));
            end
            if (l == 1 && c == 0 && !GATED) begin
               chk("wide_wrap_d2", bd2, '0);
               chk("wide_wrap_d3", bd3, '0);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
